inv_mix_columns_iter: RTL and testbench

Iterative InvMixColumns engine for the AES-128 decryption datapath. It is the inverse of the encryption-side MixColumns, which is built on the GF(2^8) multiply-by-2 lookup.
- Accepts one 128-bit state through a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock using GF(2^8) multiplies by 0x0E, 0x0B, 0x0D and 0x09.
- Holds the result until the downstream stage accepts it.
- Sits between AddRoundKey and InvShiftRows/InvSubBytes in the decryption round loop.

---
 rtl/inv_mix_columns_iter.sv | 128 ++++++++++++
 tb/tb_inv_mix_columns_iter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: loads one 128-bit state, transforms COLS_PER_CYCLE
// columns per clock in place, then holds the result until downstream accepts it.
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // A step of 4 wraps to 0 in the 2-bit counter, which is exactly what a single-group pass needs.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       fsm_q, fsm_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] state_q, state_d;
    logic [127:0] mixed;
    logic [1:0]   off;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            s[i]  = c[31-8*i -: 8];
            x2    = xtime(s[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        in_ready = !reset && ((fsm_q == IDLE) || (fsm_q == DONE && out_ready));
        accept   = in_valid && in_ready;

        // Columns col..col+COLS_PER_CYCLE-1 (mod 4) are the current group.
        mixed = state_q;
        off   = '0;
        for (int c = 0; c < 4; c++) begin
            off = 2'(c) - col_q;
            if ({1'b0, off} < 3'(COLS_PER_CYCLE)) begin
                mixed[127-32*c -: 32] = inv_mix_col(state_q[127-32*c -: 32]);
            end
        end

        fsm_d   = fsm_q;
        col_d   = col_q;
        state_d = state_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_data;
                    col_d   = '0;
                    fsm_d   = BUSY;
                end
            end
            BUSY: begin
                state_d = mixed;
                col_d   = col_q + COL_STEP;
                if (col_q == LAST_COL) fsm_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = in_data;
                        col_d   = '0;
                        fsm_d   = BUSY;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            col_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            col_q   <= col_d;
            state_q <= state_d;
        end
    end

    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == BUSY);
    assign out_data  = state_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: directed vectors, backpressure, streaming,
// and a MixColumns -> InvMixColumns round trip against a GF(2^8) matrix model.
module tb_inv_mix_columns_iter;

    localparam logic [127:0] KV_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] KV_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] C6     = {4{32'hc6c6c6c6}};
    localparam logic [127:0] B3_IN  = {4{32'h4d7ebdf8}};
    localparam logic [127:0] B3_OUT = {4{32'h2d26314c}};

    logic         clk = 0;
    logic         reset;
    logic         in_valid, in_valid2, in_valid4;
    logic         in_ready, in_ready2, in_ready4;
    logic [127:0] in_data;
    logic         out_valid, out_valid2, out_valid4;
    logic         out_ready;
    logic [127:0] out_data, out_data2, out_data4;
    logic         busy, busy2, busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));
    inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .busy(busy2));
    inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4));

    // Generic shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    // Circulant matrix product per column; row r uses coef[(j - r) mod 4] for input byte j.
    function automatic logic [127:0] mat_cols(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r = '0;
        if (inv) begin coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09; end
        else     begin coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01; end
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row + 4) % 4], s[127-32*c-8*j -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Presents d with out_ready high; lat counts from the accept cycle to the first out_valid cycle.
    task automatic send(input logic [127:0] d, output logic [127:0] q, output int lat);
        int n;
        @(negedge clk);
        in_data = d; in_valid = 1; out_ready = 1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) chk("send_ready_timeout", 128'(n), 128'(0));
        @(negedge clk);
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        q = out_data;
    endtask

    initial begin
        logic [127:0] q, d1, d2, d4, hold, s, m;
        int           lat, l1, l2, l4, n, idx;
        logic         bad_rdy, bad_dat, bad_vld, stale;
        logic [127:0] blk [3];
        logic [127:0] exp3 [3];
        int           ocyc [$];
        logic [127:0] odat [$];

        reset = 1; in_valid = 0; in_valid2 = 0; in_valid4 = 0; out_ready = 1; in_data = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_data", out_data, '0);
        reset = 0;
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        // Known vector, CPC=1
        send(KV_IN, q, lat);
        chk("kv_data", q, KV_OUT);
        chk("kv_latency", 128'(lat), 128'(5));

        // Parameter sweep: all three widths in parallel
        @(negedge clk);
        in_data = KV_IN; in_valid = 1; in_valid2 = 1; in_valid4 = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0; in_valid2 = 0; in_valid4 = 0;
        l1 = 0; l2 = 0; l4 = 0; d1 = '0; d2 = '0; d4 = '0;
        for (int k = 1; k <= 8; k++) begin
            if (out_valid  && l1 == 0) begin l1 = k; d1 = out_data;  end
            if (out_valid2 && l2 == 0) begin l2 = k; d2 = out_data2; end
            if (out_valid4 && l4 == 0) begin l4 = k; d4 = out_data4; end
            @(negedge clk);
        end
        chk("sweep1_lat", 128'(l1), 128'(5));
        chk("sweep2_lat", 128'(l2), 128'(3));
        chk("sweep4_lat", 128'(l4), 128'(2));
        chk("sweep1_data", d1, KV_OUT);
        chk("sweep2_data", d2, KV_OUT);
        chk("sweep4_data", d4, KV_OUT);

        // Reset asserted for 2 cycles mid-BUSY
        @(negedge clk);
        in_data = KV_IN; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("midrst_in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        reset = 0;
        #1;
        chk("midrst_rel_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_rel_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_rel_out_data", out_data, '0);
        chk("midrst_rel_busy", 128'(busy), 128'(0));
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid || busy) stale = 1;
        end
        chk("midrst_no_stale", 128'(stale), 128'(0));

        // Backpressure in DONE with the next block waiting
        @(negedge clk);
        in_data = KV_IN; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_data = C6;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_reach_done", 128'(out_valid), 128'(1));
        hold = out_data;
        chk("bp_data", hold, KV_OUT);
        bad_rdy = 0; bad_dat = 0; bad_vld = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (in_ready !== 1'b0) bad_rdy = 1;
            if (out_data !== hold) bad_dat = 1;
            if (out_valid !== 1'b1) bad_vld = 1;
        end
        chk("bp_in_ready_low", 128'(bad_rdy), 128'(0));
        chk("bp_data_stable", 128'(bad_dat), 128'(0));
        chk("bp_valid_held", 128'(bad_vld), 128'(0));
        @(negedge clk);
        out_ready = 1;
        #1;
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 0;
        chk("bp_accepted_busy", 128'(busy), 128'(1));
        chk("bp_accepted_no_valid", 128'(out_valid), 128'(0));
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_second_data", out_data, C6);
        @(negedge clk);

        // Back-to-back stream of 3 blocks
        blk[0] = KV_IN; blk[1] = C6;  blk[2] = B3_IN;
        exp3[0] = KV_OUT; exp3[1] = C6; exp3[2] = B3_OUT;
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (out_valid) begin ocyc.push_back(cyc); odat.push_back(out_data); end
            in_valid = (idx < 3);
            if (idx < 3) in_data = blk[idx];
            out_ready = 1;
            #1;
            if (in_valid && in_ready) idx++;
        end
        in_valid = 0;
        chk("b2b_count", 128'(ocyc.size()), 128'(3));
        if (ocyc.size() == 3) begin
            for (int k = 0; k < 3; k++) chk($sformatf("b2b_data%0d", k), odat[k], exp3[k]);
            chk("b2b_first_cycle", 128'(ocyc[0]), 128'(5));
            chk("b2b_gap01", 128'(ocyc[1] - ocyc[0]), 128'(5));
            chk("b2b_gap12", 128'(ocyc[2] - ocyc[1]), 128'(5));
        end

        // Round trip: random s -> MixColumns model -> DUT must return s
        for (int k = 0; k < 1000; k++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            m = mat_cols(s, 1'b0);
            send(m, q, lat);
            chk($sformatf("rt%0d", k), q, s);
            if (k % 250 == 0) chk($sformatf("rt_model%0d", k), mat_cols(m, 1'b1), s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
